hazard_fwd_unit: RTL and testbench

//  Parametrised hazard/forwarding controller for the pipelined MIPS core; replaces the pure-combinational bypass mux select.

---
 rtl/hazard_fwd_unit.sv | 125 ++++++++++++
 tb/tb_hazard_fwd_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_unit
// Purpose  : Tnew/Tuse hazard detection over a shadow pipeline of in-flight
//            destination tags; drives ID stall, ID/EX bypass selects and the
//            mult/div busy interlock.
// Revision : 1.0  initial release
// ============================================================================
module hazard_fwd_unit #(
    parameter int AW      = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int TW      = 2,
    parameter int MD_LAT  = 5,
    parameter int SELW    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    id_valid,
    input  logic [NUM_SRC*AW-1:0]   id_src_addr,
    input  logic [NUM_SRC*TW-1:0]   id_src_tuse,
    input  logic                    id_dst_we,
    input  logic [AW-1:0]           id_dst_addr,
    input  logic [TW-1:0]           id_dst_tnew,
    input  logic                    id_md_start,
    input  logic                    id_md_use,
    input  logic                    flush,
    output logic                    stall,
    output logic [NUM_SRC*SELW-1:0] id_fwd_sel,
    output logic [NUM_SRC*SELW-1:0] ex_fwd_sel,
    output logic                    md_busy
);

    localparam int MCW = $clog2(MD_LAT + 1);

    logic [DEPTH:1]        r_valid;
    logic [DEPTH:1]        r_we;
    logic [AW-1:0]         r_addr [1:DEPTH];
    logic [TW-1:0]         r_tnew [1:DEPTH];
    logic [NUM_SRC*AW-1:0] r_src1;
    logic                  r_md1;
    logic [MCW-1:0]        r_md_cnt;

    logic                    w_hazard;
    logic                    w_md_hold;
    logic                    w_stall;
    logic                    w_load;
    logic [SELW-1:0]         w_id_k;
    logic [SELW-1:0]         w_ex_k;
    logic [NUM_SRC*SELW-1:0] w_id_sel;
    logic [NUM_SRC*SELW-1:0] w_ex_sel;

    always_comb begin
        w_hazard = 1'b0;
        w_id_sel = '0;
        w_ex_sel = '0;
        w_id_k   = '0;
        w_ex_k   = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            w_id_k = '0;
            w_ex_k = '0;
            // Descending scan: the youngest (lowest k) match is the one left standing.
            for (int k = DEPTH; k >= 1; k--) begin
                if (r_valid[k] && r_we[k] && (r_addr[k] != '0)
                        && (r_addr[k] == id_src_addr[s*AW +: AW]))
                    w_id_k = SELW'(k);
                if ((k >= 2) && r_valid[k] && r_we[k] && (r_addr[k] != '0)
                        && (r_addr[k] == r_src1[s*AW +: AW]))
                    w_ex_k = SELW'(k);
            end
            if (w_id_k != '0) begin
                if (r_tnew[w_id_k] > id_src_tuse[s*TW +: TW])
                    w_hazard = 1'b1;
                if (r_tnew[w_id_k] == '0)
                    w_id_sel[s*SELW +: SELW] = w_id_k;
            end
            if (r_valid[1] && (w_ex_k != '0) && (r_tnew[w_ex_k] == '0))
                w_ex_sel[s*SELW +: SELW] = w_ex_k;
        end
    end

    assign w_md_hold = (r_md_cnt != '0) || (r_valid[1] && r_md1);
    assign w_stall   = (id_valid && w_hazard) || (id_md_use && w_md_hold);
    assign w_load    = id_valid && !w_stall && !flush;

    // Outputs are forced quiet while reset is asserted, whatever the shadow holds.
    assign stall      = !reset && w_stall;
    assign md_busy    = !reset && (r_md_cnt != '0);
    assign id_fwd_sel = reset ? '0 : w_id_sel;
    assign ex_fwd_sel = reset ? '0 : w_ex_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid  <= '0;
            r_we     <= '0;
            r_src1   <= '0;
            r_md1    <= 1'b0;
            r_md_cnt <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_addr[k] <= '0;
                r_tnew[k] <= '0;
            end
        end else begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_we[k]    <= r_we[k-1];
                r_addr[k]  <= r_addr[k-1];
                r_tnew[k]  <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - 1'b1;
            end
            r_valid[1] <= w_load;
            r_we[1]    <= w_load && id_dst_we;
            r_addr[1]  <= w_load ? id_dst_addr : '0;
            r_tnew[1]  <= w_load ? id_dst_tnew : '0;
            r_src1     <= w_load ? id_src_addr : '0;
            r_md1      <= w_load && id_md_start;

            if (r_valid[1] && r_md1)
                r_md_cnt <= MCW'(MD_LAT);
            else if (r_md_cnt != '0)
                r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// Testbench for hazard_fwd_unit: directed pipeline scenarios from a vector table,
// then random traffic checked against an instruction-level reference model.
module tb_hazard_fwd_unit;

    localparam int MD_LAT = 5;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [9:0] id_src_addr;
    logic [3:0] id_src_tuse;
    logic       id_dst_we;
    logic [4:0] id_dst_addr;
    logic [1:0] id_dst_tnew;
    logic       id_md_start;
    logic       id_md_use;
    logic       flush;
    logic       stall;
    logic [3:0] id_fwd_sel;
    logic [3:0] ex_fwd_sel;
    logic       md_busy;

    hazard_fwd_unit dut (
        .clk         (clk),
        .reset       (reset),
        .id_valid    (id_valid),
        .id_src_addr (id_src_addr),
        .id_src_tuse (id_src_tuse),
        .id_dst_we   (id_dst_we),
        .id_dst_addr (id_dst_addr),
        .id_dst_tnew (id_dst_tnew),
        .id_md_start (id_md_start),
        .id_md_use   (id_md_use),
        .flush       (flush),
        .stall       (stall),
        .id_fwd_sel  (id_fwd_sel),
        .ex_fwd_sel  (ex_fwd_sel),
        .md_busy     (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, v, we, ms, mu, fl;
        logic [4:0] s0, s1, d;
        logic [1:0] u0, u1, tn;
        logic       est, ebz;
        logic [3:0] eid, eex;
    } vec_t;

    // Reference model: each slot holds a whole in-flight instruction; its
    // remaining Tnew is derived from the issue-time value and its stage.
    typedef struct {
        bit       v, we, md;
        bit [4:0] dst, s0, s1;
        int       tnew0;
    } slot_t;

    slot_t pipe [1:3];
    int    cyc    = 0;
    int    md_end = 0;
    int    n_cmp  = 0;
    int    n_bad  = 0;
    vec_t  tbl [$];

    function automatic vec_t mk(input int rst, v, s0, s1, u0, u1, we, d, tn, ms, mu, fl,
                                input int st, i0, i1, e0, e1, bz);
        vec_t r;
        r.rst = 1'(rst); r.v  = 1'(v);  r.we = 1'(we);
        r.ms  = 1'(ms);  r.mu = 1'(mu); r.fl = 1'(fl);
        r.s0  = 5'(s0);  r.s1 = 5'(s1); r.d  = 5'(d);
        r.u0  = 2'(u0);  r.u1 = 2'(u1); r.tn = 2'(tn);
        r.est = 1'(st);  r.ebz = 1'(bz);
        r.eid = {2'(i1), 2'(i0)};
        r.eex = {2'(e1), 2'(e0)};
        return r;
    endfunction

    function automatic vec_t nop(input int st, e0, e1, bz);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, st, 0, 0, e0, e1, bz);
    endfunction

    function automatic int tnew_at(input int k);
        int t;
        t = pipe[k].tnew0 - (k - 1);
        return (t < 0) ? 0 : t;
    endfunction

    function automatic int youngest(input bit [4:0] a, input int lo);
        for (int k = lo; k <= 3; k++)
            if (pipe[k].v && pipe[k].we && a != 0 && pipe[k].dst == a) return k;
        return 0;
    endfunction

    task automatic model_eval(input vec_t v, output logic st, output logic [3:0] idl,
                              output logic [3:0] exl, output logic bz);
        bit [4:0] a_id [2];
        bit [4:0] a_ex [2];
        int       tu [2];
        int       k;
        st = 0; idl = 0; exl = 0; bz = 0;
        if (v.rst) return;
        a_id[0] = v.s0; a_id[1] = v.s1;
        a_ex[0] = pipe[1].s0; a_ex[1] = pipe[1].s1;
        tu[0] = int'(v.u0); tu[1] = int'(v.u1);
        for (int s = 0; s < 2; s++) begin
            k = youngest(a_id[s], 1);
            if (k != 0) begin
                if (v.v && tnew_at(k) > tu[s]) st = 1;
                if (tnew_at(k) == 0) idl[s*2 +: 2] = 2'(k);
            end
            k = youngest(a_ex[s], 2);
            if (pipe[1].v && k != 0 && tnew_at(k) == 0) exl[s*2 +: 2] = 2'(k);
        end
        bz = (cyc < md_end);
        if (v.mu && (bz || (pipe[1].v && pipe[1].md))) st = 1;
    endtask

    task automatic clear_slot(input int k);
        pipe[k].v = 0; pipe[k].we = 0; pipe[k].md = 0;
        pipe[k].dst = 0; pipe[k].s0 = 0; pipe[k].s1 = 0; pipe[k].tnew0 = 0;
    endtask

    task automatic model_step(input vec_t v, input logic st);
        if (v.rst) begin
            for (int k = 1; k <= 3; k++) clear_slot(k);
            md_end = 0;
        end else begin
            if (pipe[1].v && pipe[1].md) md_end = cyc + 1 + MD_LAT;
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            clear_slot(1);
            if (v.v && !st && !v.fl) begin
                pipe[1].v = 1; pipe[1].we = v.we; pipe[1].md = v.ms;
                pipe[1].dst = v.d; pipe[1].s0 = v.s0; pipe[1].s1 = v.s1;
                pipe[1].tnew0 = int'(v.tn);
            end
        end
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp_v);
        end
    endtask

    task automatic drive(input vec_t v);
        reset       = v.rst;
        id_valid    = v.v;
        id_src_addr = {v.s1, v.s0};
        id_src_tuse = {v.u1, v.u0};
        id_dst_we   = v.we;
        id_dst_addr = v.d;
        id_dst_tnew = v.tn;
        id_md_start = v.ms;
        id_md_use   = v.mu;
        flush       = v.fl;
    endtask

    task automatic step(input vec_t v, input bit use_model);
        logic       mst, mbz;
        logic [3:0] mid, mex;
        drive(v);
        #3;
        model_eval(v, mst, mid, mex, mbz);
        if (use_model) begin
            v.est = mst; v.eid = mid; v.eex = mex; v.ebz = mbz;
        end
        chk("stall",      {7'd0, stall},      {7'd0, v.est});
        chk("id_fwd_sel", {4'd0, id_fwd_sel}, {4'd0, v.eid});
        chk("ex_fwd_sel", {4'd0, ex_fwd_sel}, {4'd0, v.eex});
        chk("md_busy",    {7'd0, md_busy},    {7'd0, v.ebz});
        @(posedge clk);
        #1;
        model_step(v, mst);
    endtask

    initial begin
        vec_t rv;
        drive(nop(0, 0, 0, 0));
        reset = 1'b1;
        for (int k = 1; k <= 3; k++) clear_slot(k);
        @(posedge clk);
        #1;

        //              rst v  s0  s1 u0 u1 we d   tn ms mu fl   st i0 i1 e0 e1 bz
        tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        // load-use: lw $8 then addu rs=$8
        tbl.push_back(mk(0, 1, 1,  0, 1, 3, 1, 8,  2, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8,  0, 1, 1, 1, 11, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8,  0, 1, 1, 1, 11, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0, 3, 0, 0));
        // ALU-ALU: no stall, EX/MEM bypass on both operands
        tbl.push_back(mk(0, 1, 2,  3, 1, 1, 1, 9,  1, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9,  9, 1, 1, 1, 12, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0, 2, 2, 0));
        // two writers of $10 then beq: youngest decides
        tbl.push_back(mk(0, 1, 4,  5, 1, 1, 1, 10, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 4,  5, 1, 1, 1, 10, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 10, 0, 0, 0, 0, 0,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 10, 0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 2, 0, 0, 0, 0));
        tbl.push_back(nop(0, 3, 0, 0));
        // $0 never forwards or stalls
        tbl.push_back(mk(0, 1, 6,  7, 1, 1, 1, 0,  1, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0, 0, 0, 0));
        // mult then mflo: six stall cycles, five busy cycles
        tbl.push_back(mk(0, 1, 13, 14, 1, 1, 0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0,  0, 3, 3, 1, 15, 1, 0, 1, 0,   1, 0, 0, 0, 0, 0));
        for (int i = 0; i < MD_LAT; i++)
            tbl.push_back(mk(0, 1, 0, 0, 3, 3, 1, 15, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0,  0, 3, 3, 1, 15, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0, 0, 0, 0));
        // flush during load-use stall, then reset while mult/div is busy
        tbl.push_back(mk(0, 1, 1,  0, 1, 3, 1, 16, 2, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16, 0, 1, 1, 1, 17, 1, 0, 0, 1,   1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16, 0, 1, 1, 1, 17, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 13, 14, 1, 1, 0, 0, 0, 1, 1, 0,   0, 0, 0, 3, 0, 0));
        tbl.push_back(nop(0, 0, 0, 0));
        tbl.push_back(nop(0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 17, 0, 0, 0, 0, 0,  0, 0, 1, 0,   0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i], 1'b0);

        rv = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(rv, 1'b1);
        for (int n = 0; n < 3000; n++) begin
            rv.rst = ($urandom_range(0, 149) == 0);
            rv.v   = ($urandom_range(0, 3) != 0);
            rv.s0  = 5'($urandom_range(0, 3));
            rv.s1  = 5'($urandom_range(0, 3));
            rv.u0  = 2'($urandom_range(0, 3));
            rv.u1  = 2'($urandom_range(0, 3));
            rv.we  = ($urandom_range(0, 3) != 0);
            rv.d   = 5'($urandom_range(0, 3));
            rv.tn  = 2'($urandom_range(0, 3));
            rv.ms  = ($urandom_range(0, 7) == 0);
            rv.mu  = ($urandom_range(0, 5) == 0);
            rv.fl  = ($urandom_range(0, 9) == 0);
            step(rv, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
